// File: rtl/sram_loader_pkg.sv
// Shared types and default sizes for the SRAM region loader.
package sram_loader_pkg;

   localparam int DEF_NUM_REGIONS = 6;
   localparam int DEF_ADDR_W      = 22;
   localparam int DEF_DATA_W      = 32;
   localparam int DEF_CNT_W       = 24;

   // Descriptor fields are sized for the widest supported configuration
   // (ADDR_W and CNT_W up to 32); narrower builds leave the upper bits at zero.
   localparam int DESC_ADDR_MAX_W = 32;
   localparam int DESC_CNT_MAX_W  = 32;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      LOAD,
      FLUSH,
      DONE
   } state_t;

   typedef struct packed {
      logic [DESC_ADDR_MAX_W-1:0] base;
      logic [DESC_CNT_MAX_W-1:0]  nbytes;
   } desc_t;

endpackage

// File: rtl/sram_region_loader_byte_packer.sv
// Packs a little-endian byte stream into BRAM words and drives the
// registered BRAM write port (full words and partial flush words).
module byte_packer #(
   parameter int  ADDR_W = 22,
   parameter int  DATA_W = 32,
   localparam int BPW    = DATA_W / 8,
   localparam int LANE_W = (BPW > 1) ? $clog2(BPW) : 1
) (
   input  logic              i_clk,
   input  logic              i_rstn,
   input  logic              i_clear,
   input  logic              i_push,
   input  logic [7:0]        i_byte,
   input  logic              i_flush,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              o_last_lane,
   output logic              o_bram_en,
   output logic              o_bram_wr_en,
   output logic [ADDR_W-1:0] o_bram_addr,
   output logic [DATA_W-1:0] o_bram_wrdata,
   output logic [BPW-1:0]    o_bram_be
);

   logic [LANE_W-1:0] r_lane;
   logic [DATA_W-1:0] r_data;
   logic              r_en;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wrdata;
   logic [BPW-1:0]    r_be;

   logic [DATA_W-1:0] w_merged;
   logic [BPW-1:0]    w_flush_be;

   assign o_last_lane = (r_lane == LANE_W'(BPW - 1));
   assign w_flush_be  = BPW'((1 << r_lane) - 1);

   // Current partial word with the incoming byte dropped into its lane.
   always_comb begin
      // NOTE: default first so every path assigns the whole vector; no latch.
      w_merged = r_data;
      w_merged[8*r_lane +: 8] = i_byte;
   end

   // Lane accumulation and the one-cycle registered BRAM write strobe.
   always_ff @(posedge i_clk) begin
      // NOTE: non-blocking throughout so every register samples pre-edge values.
      if (!i_rstn) begin
         r_lane   <= '0;
         r_data   <= '0;
         r_en     <= 1'b0;
         r_addr   <= '0;
         r_wrdata <= '0;
         r_be     <= '0;
      end else begin
         r_en     <= 1'b0;
         r_wrdata <= '0;
         r_be     <= '0;
         if (i_clear) begin
            r_lane <= '0;
            r_data <= '0;
         end else if (i_push) begin
            if (o_last_lane) begin
               r_en     <= 1'b1;
               r_addr   <= i_addr;
               r_wrdata <= w_merged;
               r_be     <= '1;
               r_lane   <= '0;
               r_data   <= '0;
            end else begin
               r_data <= w_merged;
               r_lane <= r_lane + 1'b1;
            end
         end else if (i_flush) begin
            r_en     <= 1'b1;
            r_addr   <= i_addr;
            r_wrdata <= r_data;
            r_be     <= w_flush_be;
            r_lane   <= '0;
            r_data   <= '0;
         end
      end
   end

   assign o_bram_en     = r_en;
   assign o_bram_wr_en  = r_en;
   assign o_bram_addr   = r_addr;
   assign o_bram_wrdata = r_wrdata;
   assign o_bram_be     = r_be;

endmodule

// File: rtl/sram_region_loader.sv
// Walks a table of (base, byte count) descriptors and streams bytes from
// s_data into BRAM, one region after another.
module sram_region_loader
   import sram_loader_pkg::*;
#(
   parameter int  NUM_REGIONS = DEF_NUM_REGIONS,
   parameter int  ADDR_W      = DEF_ADDR_W,
   parameter int  DATA_W      = DEF_DATA_W,
   parameter int  CNT_W       = DEF_CNT_W,
   localparam int IDX_W       = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1,
   localparam int BPW         = DATA_W / 8
) (
   input  logic              bram_clk,
   input  logic              bram_rstn,
   input  logic              cfg_we,
   input  logic [IDX_W-1:0]  cfg_idx,
   input  logic [ADDR_W-1:0] cfg_base,
   input  logic [CNT_W-1:0]  cfg_nbytes,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              err,
   input  logic              s_valid,
   input  logic [7:0]        s_data,
   output logic              s_ready,
   output logic              bram_en,
   output logic              bram_wr_en,
   output logic [ADDR_W-1:0] bram_addr,
   output logic [DATA_W-1:0] bram_wrdata,
   output logic [BPW-1:0]    bram_be
);

   state_t            r_state;
   state_t            w_state_nxt;
   desc_t             r_desc [NUM_REGIONS];
   logic [IDX_W-1:0]  r_idx;
   logic [ADDR_W-1:0] r_addr;
   logic [CNT_W-1:0]  r_remaining;
   logic              r_err;

   logic w_accept;
   logic w_last_byte;
   logic w_last_idx;
   logic w_cur_empty;
   logic w_last_lane;
   logic w_cfg_ok;
   logic w_clear;
   logic w_flush;

   assign w_accept    = (r_state == LOAD) && s_valid;
   assign w_last_byte = w_accept && (r_remaining == CNT_W'(1));
   assign w_last_idx  = (r_idx == IDX_W'(NUM_REGIONS - 1));
   assign w_cur_empty = (CNT_W'(r_desc[r_idx].nbytes) == '0);
   assign w_cfg_ok    = ({1'b0, cfg_idx} < (IDX_W + 1)'(NUM_REGIONS));
   assign w_clear     = (r_state == SETUP);
   assign w_flush     = (r_state == FLUSH);

   // Next-state selection: skip empty slots, flush partial tail words.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (start) w_state_nxt = SETUP;
         SETUP: begin
            if (!w_cur_empty)    w_state_nxt = LOAD;
            else if (w_last_idx) w_state_nxt = DONE;
         end
         LOAD: begin
            if (w_last_byte) begin
               if (!w_last_lane)    w_state_nxt = FLUSH;
               else if (w_last_idx) w_state_nxt = DONE;
               else                 w_state_nxt = SETUP;
            end
         end
         FLUSH:   w_state_nxt = w_last_idx ? DONE : SETUP;
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // State, descriptor table, region cursor and sticky error.
   always_ff @(posedge bram_clk) begin
      if (!bram_rstn) begin
         r_state     <= IDLE;
         r_idx       <= '0;
         r_addr      <= '0;
         r_remaining <= '0;
         r_err       <= 1'b0;
         // NOTE: the descriptor table is flop-based and must come up empty, so it is reset.
         for (int i = 0; i < NUM_REGIONS; i++) r_desc[i] <= '0;
      end else begin
         r_state <= w_state_nxt;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_idx <= '0;
                  r_err <= 1'b0;
               end
               if (cfg_we && w_cfg_ok) begin
                  r_desc[cfg_idx].base   <= DESC_ADDR_MAX_W'(cfg_base);
                  r_desc[cfg_idx].nbytes <= DESC_CNT_MAX_W'(cfg_nbytes);
               end
            end
            SETUP: begin
               r_addr      <= ADDR_W'(r_desc[r_idx].base);
               r_remaining <= CNT_W'(r_desc[r_idx].nbytes);
               if (w_cur_empty && !w_last_idx) r_idx <= r_idx + 1'b1;
            end
            LOAD: begin
               if (w_accept) begin
                  r_remaining <= r_remaining - 1'b1;
                  if (w_last_lane) begin
                     r_addr <= r_addr + 1'b1;
                     // Wrapping past the top of BRAM with bytes still to go.
                     if ((&r_addr) && !w_last_byte) r_err <= 1'b1;
                     if (w_last_byte && !w_last_idx) r_idx <= r_idx + 1'b1;
                  end
               end
            end
            FLUSH: begin
               if (!w_last_idx) r_idx <= r_idx + 1'b1;
            end
            default: ;
         endcase
         if (cfg_we && (r_state != IDLE)) r_err <= 1'b1;
      end
   end

   byte_packer #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_packer (
      .i_clk         (bram_clk),
      .i_rstn        (bram_rstn),
      .i_clear       (w_clear),
      .i_push        (w_accept),
      .i_byte        (s_data),
      .i_flush       (w_flush),
      .i_addr        (r_addr),
      .o_last_lane   (w_last_lane),
      .o_bram_en     (bram_en),
      .o_bram_wr_en  (bram_wr_en),
      .o_bram_addr   (bram_addr),
      .o_bram_wrdata (bram_wrdata),
      .o_bram_be     (bram_be)
   );

   assign busy    = (r_state != IDLE);
   assign done    = (r_state == DONE);
   assign s_ready = (r_state == LOAD);
   assign err     = r_err;

endmodule

// File: tb/tb_sram_region_loader.sv
// Directed bench for sram_region_loader with a behavioural packing model.
module tb_sram_region_loader;

   localparam int NUM_REGIONS = 6;
   localparam int ADDR_W      = 22;
   localparam int DATA_W      = 32;
   localparam int CNT_W       = 24;
   localparam int BPW         = DATA_W / 8;
   localparam int IDX_W       = 3;

   logic              bram_clk = 1'b0;
   logic              bram_rstn;
   logic              cfg_we;
   logic [IDX_W-1:0]  cfg_idx;
   logic [ADDR_W-1:0] cfg_base;
   logic [CNT_W-1:0]  cfg_nbytes;
   logic              start;
   logic              busy;
   logic              done;
   logic              err;
   logic              s_valid;
   logic [7:0]        s_data;
   logic              s_ready;
   logic              bram_en;
   logic              bram_wr_en;
   logic [ADDR_W-1:0] bram_addr;
   logic [DATA_W-1:0] bram_wrdata;
   logic [BPW-1:0]    bram_be;

   always #5 bram_clk = ~bram_clk;

   sram_region_loader dut (
      .bram_clk    (bram_clk),
      .bram_rstn   (bram_rstn),
      .cfg_we      (cfg_we),
      .cfg_idx     (cfg_idx),
      .cfg_base    (cfg_base),
      .cfg_nbytes  (cfg_nbytes),
      .start       (start),
      .busy        (busy),
      .done        (done),
      .err         (err),
      .s_valid     (s_valid),
      .s_data      (s_data),
      .s_ready     (s_ready),
      .bram_en     (bram_en),
      .bram_wr_en  (bram_wr_en),
      .bram_addr   (bram_addr),
      .bram_wrdata (bram_wrdata),
      .bram_be     (bram_be)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic [BPW-1:0]    be;
   } wr_t;

   wr_t wr_q[$];
   wr_t exp_q[$];

   // Every BRAM write strobe seen at a rising edge is logged.
   always @(posedge bram_clk) begin
      if (bram_en && bram_wr_en) wr_q.push_back('{bram_addr, bram_wrdata, bram_be});
   end

   logic [ADDR_W-1:0] m_base [NUM_REGIONS];
   int                m_n    [NUM_REGIONS];

   task automatic model_reset();
      for (int i = 0; i < NUM_REGIONS; i++) begin
         m_base[i] = '0;
         m_n[i]    = 0;
      end
   endtask

   // Expected write list for a byte stream 0,1,2,... and the cycle count from
   // the start edge to the first cycle that shows done.
   task automatic build_expected(output int lat);
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
      int lane;
      int b;
      exp_q.delete();
      b   = 0;
      lat = 1;
      for (int r = 0; r < NUM_REGIONS; r++) begin
         lat += 1;
         if (m_n[r] > 0) begin
            a    = m_base[r];
            d    = '0;
            lane = 0;
            for (int k = 0; k < m_n[r]; k++) begin
               d[8*lane +: 8] = 8'(b);
               b++;
               lane++;
               if (lane == BPW) begin
                  exp_q.push_back('{a, d, {BPW{1'b1}}});
                  a    = a + 1'b1;
                  d    = '0;
                  lane = 0;
               end
            end
            lat += m_n[r];
            if (lane != 0) begin
               exp_q.push_back('{a, d, BPW'((1 << lane) - 1)});
               lat += 1;
            end
         end
      end
   endtask

   task automatic do_reset();
      @(negedge bram_clk);
      bram_rstn = 1'b0;
      repeat (2) @(negedge bram_clk);
      bram_rstn = 1'b1;
      model_reset();
   endtask

   task automatic cfg_write(input int idx, input logic [ADDR_W-1:0] base, input int n);
      @(negedge bram_clk);
      cfg_we     = 1'b1;
      cfg_idx    = IDX_W'(idx);
      cfg_base   = base;
      cfg_nbytes = CNT_W'(n);
      @(negedge bram_clk);
      cfg_we     = 1'b0;
      m_base[idx] = base;
      m_n[idx]    = n;
   endtask

   // Streams bytes 0,1,2,... until done shows up or the budget runs out.
   task automatic feed(input bit gaps, output int lat);
      int  b;
      int  cyc;
      bit  seen;
      b    = 0;
      cyc  = 0;
      seen = 1'b0;
      lat  = -1;
      while (cyc < 5000 && !seen) begin
         @(negedge bram_clk);
         cyc++;
         start = 1'b0;
         if (done) begin
            seen = 1'b1;
            lat  = cyc;
         end else begin
            s_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            s_data  = 8'(b);
            if (s_valid && s_ready) b++;
         end
      end
      s_valid = 1'b0;
   endtask

   task automatic run_load(input bit gaps, output int lat);
      wr_q.delete();
      @(negedge bram_clk);
      start = 1'b1;
      feed(gaps, lat);
   endtask

   // Done must be a single cycle; the extra cycle also lets the last write land.
   task automatic check_done_end(input string tag);
      @(negedge bram_clk);
      check({tag, "_done_pulse"}, {62'b0, done, busy}, 64'b0);
   endtask

   task automatic compare_writes(input string tag);
      wr_t got;
      check({tag, "_nwr"}, 64'(wr_q.size()), 64'(exp_q.size()));
      foreach (exp_q[i]) begin
         got = (i < wr_q.size()) ? wr_q[i] : '0;
         check($sformatf("%s_wr%0d", tag, i), 64'(got), 64'(exp_q[i]));
      end
   endtask

   initial begin
      int lat;
      int lat_exp;
      int acc;
      int guard;

      bram_rstn  = 1'b0;
      cfg_we     = 1'b0;
      cfg_idx    = '0;
      cfg_base   = '0;
      cfg_nbytes = '0;
      start      = 1'b0;
      s_valid    = 1'b0;
      s_data     = '0;
      model_reset();
      repeat (3) @(negedge bram_clk);

      check("rst_ctrl", {58'b0, busy, done, err, s_ready, bram_en, bram_wr_en}, 64'b0);
      check("rst_bram", {bram_addr, bram_wrdata, bram_be}, 64'b0);
      bram_rstn = 1'b1;

      // Region 0 of 8 bytes at 0x100, other slots empty.
      do_reset();
      cfg_write(0, 22'h100, 8);
      build_expected(lat_exp);
      check("t1_model_nwr", 64'(exp_q.size()), 64'd2);
      run_load(1'b0, lat);
      check("t1_lat", 64'(lat), 64'(lat_exp));
      check_done_end("t1");
      check("t1_wr0", 64'(wr_q.size() > 0 ? wr_q[0] : '0), 64'({22'h100, 32'h03020100, 4'hF}));
      check("t1_wr1", 64'(wr_q.size() > 1 ? wr_q[1] : '0), 64'({22'h101, 32'h07060504, 4'hF}));
      check("t1_nwr", 64'(wr_q.size()), 64'd2);

      // Six bytes at 0x10: one full word then a two-lane flush.
      do_reset();
      cfg_write(0, 22'h10, 6);
      build_expected(lat_exp);
      run_load(1'b0, lat);
      check("t2_lat", 64'(lat), 64'(lat_exp));
      check_done_end("t2");
      check("t2_wr0", 64'(wr_q.size() > 0 ? wr_q[0] : '0), 64'({22'h10, 32'h03020100, 4'hF}));
      check("t2_wr1", 64'(wr_q.size() > 1 ? wr_q[1] : '0), 64'({22'h11, 32'h00000504, 4'h3}));

      // All six slots, back-to-back stream: latency proves no bubbles.
      do_reset();
      for (int i = 0; i < NUM_REGIONS; i++) cfg_write(i, ADDR_W'(i * 32'h1000), 40);
      build_expected(lat_exp);
      check("t3_lat_model", 64'(lat_exp), 64'd247);
      run_load(1'b0, lat);
      check("t3_lat", 64'(lat), 64'(lat_exp));
      check_done_end("t3");
      compare_writes("t3");

      // Mixed sizes with empty slots, first gap-free then with random stalls.
      do_reset();
      cfg_write(0, 22'h020, 13);
      cfg_write(1, 22'h300, 0);
      cfg_write(2, 22'h040, 9);
      cfg_write(3, 22'h050, 4);
      cfg_write(5, 22'h070, 7);
      build_expected(lat_exp);
      check("t4_lat_model", 64'(lat_exp), 64'd43);
      run_load(1'b0, lat);
      check("t4_lat", 64'(lat), 64'(lat_exp));
      check_done_end("t4a");
      compare_writes("t4a");
      run_load(1'b1, lat);
      check("t4_gap_done", 64'(lat >= lat_exp), 64'd1);
      check_done_end("t4b");
      compare_writes("t4b");

      // Address wrap at the top of BRAM sets err; next start clears it.
      do_reset();
      cfg_write(0, 22'h3FFFFF, 8);
      build_expected(lat_exp);
      run_load(1'b0, lat);
      check("t5_lat", 64'(lat), 64'(lat_exp));
      check_done_end("t5");
      check("t5_wr0", 64'(wr_q.size() > 0 ? wr_q[0] : '0), 64'({22'h3FFFFF, 32'h03020100, 4'hF}));
      check("t5_wr1", 64'(wr_q.size() > 1 ? wr_q[1] : '0), 64'({22'h000000, 32'h07060504, 4'hF}));
      check("t5_err", {63'b0, err}, 64'd1);
      cfg_write(0, 22'h0, 4);
      run_load(1'b0, lat);
      check_done_end("t5b");
      check("t5_err_clear", {63'b0, err}, 64'd0);

      // Descriptor write while busy is dropped and flags err.
      do_reset();
      cfg_write(0, 22'h040, 8);
      build_expected(lat_exp);
      wr_q.delete();
      @(negedge bram_clk);
      start = 1'b1;
      @(negedge bram_clk);
      start      = 1'b0;
      cfg_we     = 1'b1;
      cfg_idx    = '0;
      cfg_base   = 22'h080;
      cfg_nbytes = CNT_W'(4);
      @(negedge bram_clk);
      cfg_we = 1'b0;
      check("t6_err_busy", {63'b0, err}, 64'd1);
      feed(1'b0, lat);
      check_done_end("t6");
      compare_writes("t6");
      check("t6_err_sticky", {63'b0, err}, 64'd1);

      // Reset after five bytes of region 0: abort with no further write.
      do_reset();
      cfg_write(0, 22'h200, 16);
      wr_q.delete();
      @(negedge bram_clk);
      start = 1'b1;
      acc   = 0;
      guard = 0;
      while (acc < 5 && guard < 100) begin
         @(negedge bram_clk);
         start   = 1'b0;
         cfg_we  = (guard == 0);
         guard++;
         s_valid = 1'b1;
         s_data  = 8'(acc);
         if (s_ready) acc++;
      end
      cfg_we = 1'b0;
      check("t7_bytes", 64'(acc), 64'd5);
      @(negedge bram_clk);
      check("t7_pre_nwr", 64'(wr_q.size()), 64'd1);
      check("t7_pre_wr0", 64'(wr_q.size() > 0 ? wr_q[0] : '0), 64'({22'h200, 32'h03020100, 4'hF}));
      check("t7_pre_err", {63'b0, err}, 64'd1);
      bram_rstn = 1'b0;
      s_valid   = 1'b0;
      wr_q.delete();
      @(negedge bram_clk);
      check("t7_rst_ctrl", {58'b0, busy, done, err, s_ready, bram_en, bram_wr_en}, 64'b0);
      check("t7_rst_bram", {bram_addr, bram_wrdata, bram_be}, 64'b0);
      @(negedge bram_clk);
      bram_rstn = 1'b1;
      model_reset();
      repeat (4) @(negedge bram_clk);
      check("t7_post_nwr", 64'(wr_q.size()), 64'd0);
      build_expected(lat_exp);
      run_load(1'b0, lat);
      check("t7_empty_lat", 64'(lat), 64'(lat_exp));
      check_done_end("t7");
      check("t7_empty_nwr", 64'(wr_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/sram_region_loader.md
SRAM_REGION_LOADER -- requirements
Module: sram_region_loader

Interface
REQ-001 SHALL have parameter NUM_REGIONS, default 6, number of descriptor slots (1..16).
REQ-002 SHALL have parameter ADDR_W, default 22, BRAM word-address width.
REQ-003 SHALL have parameter DATA_W, default 32, BRAM data width, multiple of 8; BPW = DATA_W/8 bytes per word.
REQ-004 SHALL have parameter CNT_W, default 24, descriptor byte-count width.
REQ-005 SHALL use one clock; reset is synchronous and active-low.
REQ-006 bram_clk  in  1  sole clock, all logic on rising edge.
REQ-007 bram_rstn  in  1  synchronous active-low reset.
REQ-008 cfg_we  in  1  write descriptor; cfg_idx  in  $clog2(NUM_REGIONS)  slot; cfg_base  in  ADDR_W  start word address; cfg_nbytes  in  CNT_W  region byte count.
REQ-009 start  in  1  begin loading regions 0..NUM_REGIONS-1; busy  out  1; done  out  1  one-cycle pulse; err  out  1  sticky error.
REQ-010 s_valid  in  1; s_data  in  8  byte stream; s_ready  out  1; byte transferred when s_valid && s_ready.
REQ-011 bram_en, bram_wr_en  out  1; bram_addr  out  ADDR_W; bram_wrdata  out  DATA_W; bram_be  out  BPW  byte enables.

Function
REQ-012 FSM states SHALL be IDLE, SETUP, LOAD, FLUSH, DONE.
REQ-013 IDLE: start=1 -> SETUP with region index 0; start while not IDLE SHALL be ignored.
REQ-014 SETUP: loads addr=base[idx], remaining=nbytes[idx], lane=0; nbytes==0 -> skip to next index (one cycle per skipped slot); else -> LOAD.
REQ-015 LOAD: s_ready=1; each accepted byte stored in lane k at bits [8k+7:8k] (little-endian), lane++, remaining--.
REQ-016 Word write SHALL be issued the cycle after the byte filling lane BPW-1 is accepted: bram_en=bram_wr_en=1 for exactly one cycle, bram_be all ones, bram_addr=current addr, then addr++ (modulo 2^ADDR_W).
REQ-017 Sustained throughput SHALL be one byte per cycle; s_ready SHALL NOT drop during a word write.
REQ-018 When remaining reaches 0 with lane!=0 -> FLUSH: one write, bram_be = low `lane` bits set, unused data lanes zero; s_ready=0 in FLUSH.
REQ-019 Region end: idx<NUM_REGIONS-1 -> SETUP with idx+1; else DONE.
REQ-020 DONE: done=1 one cycle -> IDLE; busy=1 in all states except IDLE.
REQ-021 s_ready SHALL be 0 outside LOAD; bytes after the last region are not consumed.
REQ-022 cfg_we in IDLE updates slot cfg_idx next cycle; cfg_we while busy SHALL be ignored and set err.
REQ-023 addr wrap from 2^ADDR_W-1 to 0 within a region SHALL set err; load continues.
REQ-024 err SHALL clear only on reset or on start accepted in IDLE.
REQ-025 Outputs bram_* SHALL be registered; bram_wrdata/bram_be SHALL be 0 when bram_en=0.

Reset
REQ-026 bram_rstn=0 at a rising edge SHALL force IDLE, clear all descriptors to 0, and drive busy, done, err, s_ready, bram_en, bram_wr_en, bram_addr, bram_wrdata, bram_be to 0.
REQ-027 Reset mid-load SHALL abort without a further BRAM write; partial lane data is discarded.

Structure
REQ-028 Package sram_loader_pkg SHALL hold the descriptor struct (base, nbytes), FSM state enum and parameter defaults.
REQ-029 Byte-to-word packing (lane counter, data/be register) SHALL be sub-module byte_packer; FSM and descriptor table in sram_region_loader.

Verification
REQ-030 Region0 base 0x100, nbytes 8, others 0; bytes 00..07 -> writes @0x100=0x03020100, @0x101=0x07060504, be=0xF, done one cycle later.
REQ-031 Region0 base 0x10, nbytes 6 -> @0x10=0x03020100 be=0xF, @0x11=0x00000504 be=0x3.
REQ-032 Regions 0..5 base i*0x1000, nbytes 103040 each, s_valid always 1 -> 25760 writes per region, total 6*103040 cycles in LOAD, no gaps.
REQ-033 Random s_valid gaps, region1 nbytes 0 -> region1 skipped, data identical to gap-free run.
REQ-034 Base 0x3FFFFF (ADDR_W 22), nbytes 8 -> writes @0x3FFFFF then @0x000000, err=1.
REQ-035 bram_rstn=0 after 5 bytes of region0 -> all outputs 0 next cycle, no write; cfg_we during busy -> err=1, descriptor unchanged.
